// File: rtl/fifo_rr_drain_sched.sv
// fifo_rr_drain_sched: round-robin burst drain of FWFT FIFO read ports into one tagged valid/ready stream
module fifo_rr_drain_sched #(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN = 16,
  localparam int CH_W = $clog2(NUM_CH),
  localparam int CNT_W = $clog2(BURST_LEN + 1)
) (
  input  logic                         rd_clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_CH-1:0]            fifo_rd_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_sop,
  output logic                         busy
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [CH_W-1:0] ptr, gnt, nxt;
  logic [CNT_W-1:0] cnt;
  logic first, pop, last;
  always_comb begin
    nxt = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (!fifo_empty[(int'(ptr) + k) % NUM_CH]) nxt = CH_W'((int'(ptr) + k) % NUM_CH);
  end
  assign pop = state == XFER && !rst && !fifo_empty[gnt] && (!out_valid || out_ready);
  assign last = cnt == CNT_W'(BURST_LEN - 1);
  assign fifo_rd_en = pop ? NUM_CH'(1) << gnt : '0;
  assign busy = state == XFER;
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      cnt       <= '0;
      first     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sop   <= 1'b0;
    end else begin
      if (pop) begin
        out_data  <= fifo_dout[gnt*DATA_WIDTH +: DATA_WIDTH];
        out_ch    <= gnt;
        out_valid <= 1'b1;
        out_sop   <= first;
        first     <= 1'b0;
        cnt       <= cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == IDLE && en && !(&fifo_empty)) begin
        gnt   <= nxt;
        cnt   <= '0;
        first <= 1'b1;
        state <= XFER;
      end else if (state == XFER && (fifo_empty[gnt] || (pop && last))) begin
        state <= IDLE;
        ptr   <= gnt == CH_W'(NUM_CH - 1) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule
